// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg: constants and receiver state type shared by UART RX and TX.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// +--------------------------------------------------------------------------+
// | uart_sync2: two-flop synchronizer for an asynchronous input.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// +--------------------------------------------------------------------------+
// | uart_receiver: oversampled UART receive path (8N1 by default).            |
// | Optional parity bit and parity_err strobe with UART_RX_PARITY_EN.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int c_tick_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

  logic                 w_rxs;
  uart_rx_state_t       r_state;
  logic [c_tick_w-1:0]  r_tick_cnt;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_framing_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_parity_bit;
  logic                 r_parity_err;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxd),
    .o_sync  (w_rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RX_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit  <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      // Result strobes are single-cycle regardless of tick spacing.
      r_data_valid  <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      if (rx_tick) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_rxs) begin
              r_state    <= RX_START;
              r_tick_cnt <= '0;
            end
          end
          RX_START: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == c_tick_mid) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rxs ? RX_IDLE : RX_DATA;
            end
          end
          RX_DATA: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == c_tick_last) begin
              r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                r_state <= RX_PARITY;
`else
                r_state <= RX_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          RX_PARITY: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == c_tick_last) begin
              r_parity_bit <= w_rxs;
              r_state      <= RX_STOP;
            end
          end
`endif
          RX_STOP: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == c_tick_last) begin
              r_data        <= r_shift;
              r_data_valid  <= w_rxs;
              r_framing_err <= !w_rxs;
`ifdef UART_RX_PARITY_EN
              r_parity_err  <= ((^r_shift) ^ r_parity_bit) != PARITY_ODD;
`endif
              r_state       <= RX_IDLE;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign framing_err = r_framing_err;
  assign busy        = (r_state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// +--------------------------------------------------------------------------+
// | tb_uart_receiver: directed and random frames against a frame-level model. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_receiver;

  localparam int BIT_CLK   = 64;
  localparam bit PARITY_ODD = 1'b0;

  typedef struct packed {
    logic [1:0] kind;   // {data_valid, framing_err}
    logic [7:0] d;
    logic       perr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_tick;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;
  logic       parity_err;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   wide_cnt = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  logic [7:0] exp_data;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;

  uart_receiver #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD (PARITY_ODD)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_tick     (rx_tick),
    .rxd         (rxd),
    .data        (data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // One rx_tick every 4 clk: 16 ticks per 64-clk bit.
  initial begin
    int cnt;
    cnt = 0;
    rx_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (data_valid || framing_err || parity_err)
      got_q.push_back('{kind: {data_valid, framing_err}, d: data, perr: parity_err});
    if ((data_valid && prev_dv) || (framing_err && prev_fe))
      wide_cnt++;
    prev_dv = data_valid;
    prev_fe = framing_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic hold(input logic b, input int nclk);
    rxd = b;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: outcome depends only on stop bit, byte and parity rule.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    logic perr;
    hold(1'b0, BIT_CLK);
    rxd = b[0];
    repeat (BIT_CLK / 2) @(posedge clk);
    #1;
    check("busy_mid_frame", busy, 1'b1);
    hold(b[0], BIT_CLK / 2);
    for (int i = 1; i < 8; i++) hold(b[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    hold(par_b, BIT_CLK);
    perr = ((^b) ^ par_b) != PARITY_ODD;
`else
    perr = 1'b0;
    if (par_b) perr = 1'b0;
`endif
    hold(stop_b, BIT_CLK);
    rxd = 1'b1;
    exp_q.push_back('{kind: stop_b ? 2'b10 : 2'b01, d: b, perr: perr});
    exp_data = b;
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, ".count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".kind"}, got_q[i].kind, exp_q[i].kind);
      check({tag, ".data"}, got_q[i].d, exp_q[i].d);
      check({tag, ".perr"}, got_q[i].perr, exp_q[i].perr);
    end
    check({tag, ".pulse_width"}, wide_cnt, 0);
    check({tag, ".data_hold"}, data, exp_data);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] abort_byte;
    logic       stop_b;
    logic       par_b;
    int         gap;

    rst = 1'b1;
    rxd = 1'b1;
    exp_data = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.data", data, 8'h00);
    check("reset.data_valid", data_valid, 1'b0);
    check("reset.framing_err", framing_err, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.parity_err", parity_err, 1'b0);

    // Good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, BIT_CLK);
    compare_events("frame_a5");
    check("frame_a5.busy_after", busy, 1'b0);

    // Glitch shorter than half a bit
    hold(1'b0, 16);
    hold(1'b1, 2 * BIT_CLK);
    compare_events("glitch");
    check("glitch.busy", busy, 1'b0);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b1, 2 * BIT_CLK);
    compare_events("framing");
    check("framing.busy_after", busy, 1'b0);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    hold(1'b1, BIT_CLK);
    compare_events("back2back");

    // Random frames with random gaps
    for (int k = 0; k < 10; k++) begin
      b      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = 1'($urandom);
      send_frame(b, stop_b, par_b);
      gap = stop_b ? $urandom_range(0, 2) : $urandom_range(1, 2);
      hold(1'b1, gap * BIT_CLK);
    end
    hold(1'b1, 2 * BIT_CLK);
    compare_events("random");

    // Reset in the middle of frame 0x81
    abort_byte = 8'h81;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(abort_byte[i], BIT_CLK);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_data = 8'h00;
    hold(1'b1, 2 * BIT_CLK);
    check("abort.data", data, 8'h00);
    check("abort.busy", busy, 1'b0);
    check("abort.data_valid", data_valid, 1'b0);
    check("abort.framing_err", framing_err, 1'b0);
    compare_events("abort");
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, BIT_CLK);
    compare_events("after_abort");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, BIT_CLK);
    compare_events("parity_bad");
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, BIT_CLK);
    compare_events("parity_good");
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive path, 8N1 by default, running on the 16x oversampling enable from the baud rate generator (one-cycle pulse every 326 clk; 9600 baud × 16 at 50 MHz). Synchronizes the asynchronous `rxd` line, qualifies the start bit at mid-bit, and samples each data and stop bit at its centre. Presents one received byte per frame with a one-cycle valid strobe to the host-side logic. It is the counterpart of the UART transmitter, which runs on the 1x enable.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: `rx_tick` pulses per bit period. Must be a power of 2 and ≥ 8.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `rx_tick`, input, 1: oversampling enable. One clk wide. Only clk edges with `rx_tick` = 1 advance the receiver.
- `rxd`, input, 1: asynchronous serial line. Idles high.
- `data`, output, DATA_BITS: last received word. Holds its value until the next frame completes.
- `data_valid`, output, 1: one-cycle pulse when a frame with a good stop bit completes.
- `framing_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1: high in every state except IDLE.
- `parity_err`, output, 1: one-cycle pulse on parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized `rxs`.
- Counters: `tick_cnt` is log2(OVERSAMPLE) bits and wraps naturally. `bit_cnt` is clog2(DATA_BITS) bits.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: on a tick with `rxs` = 0, go to START and set `tick_cnt` = 0.
  - START: on each tick, increment `tick_cnt`. On the tick where `tick_cnt` = OVERSAMPLE/2−1:
    - `rxs` = 0: go to DATA, `tick_cnt` = 0, `bit_cnt` = 0.
    - `rxs` = 1: false start. Go to IDLE with no output.
  - DATA: on the tick where `tick_cnt` = OVERSAMPLE−1, shift `rxs` into the MSB of the shift register (right shift, so LSB-first input lands correctly) and set `tick_cnt` = 0. After the DATA_BITS-th sample, go to PARITY if compiled in, otherwise STOP.
  - STOP: on the tick where `tick_cnt` = OVERSAMPLE−1, sample `rxs`, load `data` from the shift register, and go to IDLE.
    - `rxs` = 1: pulse `data_valid`.
    - `rxs` = 0: pulse `framing_err`. `data` is still updated. `data_valid` stays low.
- The receiver returns to IDLE at stop-bit centre. This leaves half a bit of margin, so back-to-back frames with no idle time are received.
- Outside the counts listed above, `rxs` is ignored. No majority voting.
- Reset values: state IDLE, `data` = 0, `data_valid` = 0, `framing_err` = 0, `parity_err` = 0, `busy` = 0, counters 0, shift register 0.
- Reset mid-frame aborts the frame with no strobe. The next falling edge after reset starts a new frame.
- `data_valid` and `framing_err` are never high in the same cycle.

## Timing
- Input latency: 2 clk from an `rxd` change to `rxs`.
- A falling edge is detected on the first `rx_tick` after `rxs` goes low. This gives start-detect jitter of up to one tick period (1/16 bit).
- Data-bit samples fall at 1.5, 2.5, … bit periods after detection, i.e. near bit centres.
- `data_valid`, `framing_err` and `parity_err` are registered. Each asserts on the clk edge that follows the sampling tick edge, lasts exactly 1 clk, and is independent of `rx_tick` spacing.
- `busy` rises 1 clk after the start-detect tick and falls in the same cycle the result strobe rises.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP. It is sampled at `tick_cnt` = OVERSAMPLE−1, like the other bits.
  - Parameter `PARITY_ODD` (default 0 = even) selects the sense.
  - A mismatch pulses `parity_err` in the same cycle as the stop-bit result. `data_valid` still follows the stop bit.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state, no `parity_err` port, and no `PARITY_ODD` parameter.
  - Frame is 1 start + DATA_BITS + 1 stop.

## Structure
- Shared package `uart_pkg`:
  - receiver state enum `uart_rx_state_t`;
  - `UART_OVERSAMPLE` = 16;
  - `UART_DATA_BITS` = 8.
  The transmitter uses the same constants.
- Sub-module `uart_sync2`: 2-flop synchronizer with reset value parameter `RST_VAL` (1 here). Reusable for other asynchronous inputs.

## Test plan
Unless stated otherwise, the bench drives `rx_tick` every 4 clk and generates frames on a 64-clk bit period.

1. Frame 0xA5, stop = 1 → `data` = 0xA5, `data_valid` high for exactly 1 clk, `framing_err` = 0, `busy` low afterwards.
2. `rxd` low for 4 ticks, then high (glitch) → return to IDLE, no strobes, `data` unchanged.
3. Frame 0x3C with stop bit = 0 → `framing_err` pulses once, `data_valid` stays 0, `data` = 0x3C.
4. Back-to-back frames 0x00 then 0xFF with no idle gap → two `data_valid` pulses, values 0x00 then 0xFF.
5. Assert `rst` for 1 clk after bit 3 of frame 0x81, then send 0x5A → no strobe for the aborted frame, all outputs at reset values, then `data` = 0x5A valid.
6. Build with `UART_RX_PARITY_EN` and even parity:
   - 0x81 with parity bit 1 → `parity_err` pulses together with `data_valid`;
   - 0x81 with parity bit 0 → no `parity_err`.
